// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, LSB first, one cell per cycle.
// Optional `define SERSUB_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             d;
  logic             brw_next;
  logic [WIDTH-1:0] d_sh_next;

  // NOTE: combinational cell logic uses blocking '=' and assigns every output
  // unconditionally, so no storage (latch) can be inferred here.
  always_comb begin
    x        = a_sh[0];
    y        = b_sh[0];
    d        = x ^ y ^ brw;
    brw_next = (~x & y) | (~(x ^ y) & brw);
  end

  // The result enters at the MSB; a 1-bit result is just the cell output.
  generate
    if (WIDTH == 1) begin : g_one
      assign d_sh_next = d;
    end else begin : g_many
      assign d_sh_next = {d, d_sh[WIDTH-1:1]};
    end
  endgenerate

  // The oldest accumulator bit is always shifted out before it can be consumed.
  logic unused_d_sh_lsb;
  assign unused_d_sh_lsb = d_sh[0];

  // NOTE: all state updates use non-blocking '<=' so every flop samples the
  // pre-edge values; the reset branch is asynchronous and clears every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERSUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= brw_next;
          d_sh <= d_sh_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= d_sh_next;
            bout  <= brw_next;
`ifdef SERSUB_OVF_EN
            // brw is the borrow into the MSB stage, brw_next the borrow out of it.
            ovf   <= brw ^ brw_next;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Self-checking bench for serial_full_subtractor: WIDTH=8 and WIDTH=1 instances
// checked against an arithmetic reference model with randomized operands.
module tb_serial_full_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start8 = 1'b0;
  logic [W-1:0] a8 = '0, b8 = '0;
  logic         bin8 = 1'b0;
  logic         busy8, done8, bout8;
  logic [W-1:0] diff8;

  logic start1 = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic busy1, done1, bout1, diff1;

`ifdef SERSUB_OVF_EN
  logic ovf8, ovf1;
`endif

  int checks = 0;
  int errors = 0;

  serial_full_subtractor #(.WIDTH(W)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERSUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_full_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERSUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  // Reference: plain integer arithmetic, unsigned for diff/bout, signed for ovf.
  function automatic void model8(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                                 output logic [W-1:0] d, output logic bo, output logic ov);
    int r, sa, sb, sr;
    r  = int'(a) - int'(b) - int'(bi);
    d  = r[W-1:0];
    bo = (r < 0);
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    sr = sa - sb - int'(bi);
    ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
  endfunction

  task automatic launch8(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = W'($urandom); b8 = W'($urandom); bin8 = 1'($urandom);
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b done=%b, required busy=1 done=0", busy8, done8);
    end
  endtask

  // Waits (bounded) for done; optionally pulses start at sample pulse_at while busy.
  task automatic collect8(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input int pulse_at);
    int n = 0;
    int busy_cnt = 0;
    logic [W-1:0] ed;
    logic eb, eo;
    model8(a, b, bi, ed, eb, eo);
    while (done8 !== 1'b1 && n < 40) begin
      if (busy8 === 1'b1) busy_cnt++;
      if (n == pulse_at) begin
        start8 = 1'b1; a8 = W'($urandom); b8 = W'($urandom); bin8 = 1'($urandom);
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start8 = 1'b0;
    checks++;
    if (n != W) begin
      errors++;
      $display("FAIL latency: done after %0d cycles, required %0d", n, W);
    end
    checks++;
    if (busy_cnt != W) begin
      errors++;
      $display("FAIL busy_len: busy for %0d cycles, required %0d", busy_cnt, W);
    end
    checks++;
    if (diff8 !== ed || bout8 !== eb || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL result a=%h b=%h bin=%b: diff=%h bout=%b busy=%b, required diff=%h bout=%b busy=0",
               a, b, bi, diff8, bout8, busy8, ed, eb);
    end
`ifdef SERSUB_OVF_EN
    checks++;
    if (ovf8 !== eo) begin
      errors++;
      $display("FAIL ovf a=%h b=%h bin=%b: ovf=%b, required %b", a, b, bi, ovf8, eo);
    end
`endif
  endtask

  task automatic idle8();
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL idle: busy=%b done=%b, required busy=0 done=0", busy8, done8);
    end
  endtask

  task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    launch8(a, b, bi);
    collect8(a, b, bi, -1);
    idle8();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== '0 || bout8 !== 1'b0 ||
        busy1 !== 1'b0 || done1 !== 1'b0 || diff1 !== 1'b0 || bout1 !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b diff=%h bout=%b (w1 %b%b%b%b), required all 0",
               busy8, done8, diff8, bout8, busy1, done1, diff1, bout1);
    end
`ifdef SERSUB_OVF_EN
    checks++;
    if (ovf8 !== 1'b0 || ovf1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b/%b, required 0/0", ovf8, ovf1);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    op8(8'h5A, 8'h3C, 1'b0);
    op8(8'h00, 8'h01, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_width1();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      int r;
      v = i[2:0];
      r = int'(v[2]) - int'(v[1]) - int'(v[0]);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; bin1 = v[0];
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~v[2]; b1 = ~v[1]; bin1 = ~v[0];
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL w1_accept %0d: busy=%b done=%b, required busy=1 done=0", i, busy1, done1);
      end
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || diff1 !== r[0] || bout1 !== (r < 0)) begin
        errors++;
        $display("FAIL w1_result a=%b b=%b bin=%b: done=%b busy=%b diff=%b bout=%b, required done=1 busy=0 diff=%b bout=%b",
                 v[2], v[1], v[0], done1, busy1, diff1, bout1, r[0], (r < 0));
      end
`ifdef SERSUB_OVF_EN
      begin
        int sr;
        sr = -int'(v[2]) + int'(v[1]) - int'(v[0]);
        checks++;
        if (ovf1 !== (sr < -1 || sr > 0)) begin
          errors++;
          $display("FAIL w1_ovf %0d: ovf=%b, required %b", i, ovf1, (sr < -1 || sr > 0));
        end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb, qa, qb;
    logic rbi, qbi;
    ra = 8'hC3; rb = 8'h4E; rbi = 1'b1;
    qa = 8'h17; qb = 8'hA9; qbi = 1'b0;
    launch8(ra, rb, rbi);
    collect8(ra, rb, rbi, 3);   // start re-pulsed while busy must be ignored
    launch8(qa, qb, qbi);       // start held in the done cycle is accepted
    collect8(qa, qb, qbi, -1);
    idle8();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    launch8(8'h9D, 8'h21, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== '0 || bout8 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b diff=%h bout=%b, required all 0",
               busy8, done8, diff8, bout8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL aborted_op: %0d cycles with busy/done after reset, required 0", seen);
    end
    op8(8'h5A, 8'h3C, 1'b0);
  endtask

  task automatic test_ovf();
    op8(8'h80, 8'h01, 1'b0);
    op8(8'h05, 8'h03, 1'b0);
    op8(8'h7F, 8'hFF, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic rbi;
    bit chained = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      launch8(ra, rb, rbi);
      if (!chained) begin
        // done must already be low one cycle after a non-chained completion.
      end
      collect8(ra, rb, rbi, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, W-1)) : -1);
      chained = ($urandom_range(0, 2) == 0);
      if (!chained) idle8();
    end
    idle8();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width1();
    test_back_to_back();
    test_reset_mid();
    test_ovf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
